// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: serialises the E and M register writes of one
// retiring instruction onto a single register-file write port.
module regfile_wb_sched #(
  parameter int          DATA_W = 64,
  parameter int          CNT_W  = 32,
  parameter logic [3:0]  RNONE  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [3:0]        dstE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              retire,
  output logic [CNT_W-1:0]  retire_count,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE, WR_E, WR_M, RET
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        dste_q, dstm_q, icode_q;
  logic [DATA_W-1:0] valm_q, wr_data_nxt;
  logic              pend_m_q;
  logic              acc, e_pend, m_pend;

  assign wb_ready = rst_n && (state == IDLE) && !halted;
  assign acc      = wb_valid && wb_ready;
  // a not-taken cmov keeps its E destination untouched
  assign e_pend   = (dstE != RNONE) &&
                    !((icode == 4'd2) && !cnd);
  assign m_pend   = (dstM != RNONE);

  always_comb begin
    state_nxt   = state;
    wr_data_nxt = wr_data;
    wr_en       = 1'b0;
    wr_addr     = RNONE;
    retire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) begin
          if (e_pend) begin
            state_nxt   = WR_E;
            wr_data_nxt = valE;
          end else if (m_pend) begin
            state_nxt   = WR_M;
            wr_data_nxt = valM;
          end else begin
            state_nxt   = RET;
          end
        end
      end
      WR_E: begin
        wr_en   = 1'b1;
        wr_addr = dste_q;
        if (pend_m_q) begin
          state_nxt   = WR_M;
          wr_data_nxt = valm_q;
        end else begin
          state_nxt = IDLE;
          retire    = 1'b1;
        end
      end
      WR_M: begin
        wr_en     = 1'b1;
        wr_addr   = dstm_q;
        retire    = 1'b1;
        state_nxt = IDLE;
      end
      RET: begin
        retire    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dste_q       <= RNONE;
      dstm_q       <= RNONE;
      icode_q      <= 4'd1;
      valm_q       <= '0;
      pend_m_q     <= 1'b0;
      wr_data      <= '0;
      retire_count <= '0;
      halted       <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_data <= wr_data_nxt;
      if (acc) begin
        dste_q   <= dstE;
        dstm_q   <= dstM;
        icode_q  <= icode;
        valm_q   <= valM;
        pend_m_q <= m_pend;
      end
      if (retire) begin
        retire_count <= retire_count + 1'b1;
        if (icode_q == 4'd0)
          halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: vector table plus halt,
// mid-sequence reset and counter-wrap sequences.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  icode;
  logic        cnd;
  logic [3:0]  dstE, dstM;
  logic [63:0] valE, valM;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic        retire;
  logic [3:0]  retire_count;
  logic        halted;

  regfile_wb_sched #(.DATA_W(64), .CNT_W(4), .RNONE(4'hF)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .icode(icode), .cnd(cnd),
    .dstE(dstE), .dstM(dstM),
    .valE(valE), .valM(valM),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .retire(retire), .retire_count(retire_count),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [63:0] vale;
    logic [63:0] valm;
    int          n;
    logic [3:0]  a1;
    logic [63:0] d1;
    logic [3:0]  a2;
    logic [63:0] d2;
  } vec_t;

  vec_t        tbl [9];
  int          nchk = 0;
  int          nerr = 0;
  logic [3:0]  cnt_m = 4'd0;
  logic [63:0] last_d = 64'd0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    icode = v.icode; cnd = v.cnd;
    dstE = v.dste; dstM = v.dstm;
    valE = v.vale; valM = v.valm;
    wb_valid = 1'b1;
  endtask

  // called at a negedge with wb_ready expected high
  task automatic run(input vec_t v, input logic hlt);
    chk("ready_pre", wb_ready, 1);
    drive(v);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("t1_wr_en", wr_en, v.n >= 1);
    chk("t1_addr", wr_addr, v.n >= 1 ? v.a1 : 4'hF);
    if (v.n >= 1) last_d = v.d1;
    chk("t1_data", wr_data, last_d);
    chk("t1_retire", retire, v.n <= 1);
    chk("t1_ready", wb_ready, 0);
    if (v.n == 2) begin
      @(negedge clk);
      last_d = v.d2;
      chk("t2_wr_en", wr_en, 1);
      chk("t2_addr", wr_addr, v.a2);
      chk("t2_data", wr_data, last_d);
      chk("t2_retire", retire, 1);
      chk("t2_ready", wb_ready, 0);
    end
    @(negedge clk);
    cnt_m = cnt_m + 4'd1;
    chk("post_wr_en", wr_en, 0);
    chk("post_addr", wr_addr, 4'hF);
    chk("post_data", wr_data, last_d);
    chk("post_retire", retire, 0);
    chk("post_count", retire_count, cnt_m);
    chk("post_halted", halted, hlt);
    chk("post_ready", wb_ready, !hlt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wb_valid = 1'b0;
    #1;
    chk("rst_ready", wb_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", wr_addr, 4'hF);
    chk("rst_data", wr_data, 0);
    chk("rst_count", retire_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retire", retire, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", wb_ready, 1);
    cnt_m = 4'd0;
    last_d = 64'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t nop, hlt, popq, irm;
    rst_n = 1'b1; wb_valid = 1'b0;
    icode = 4'd1; cnd = 1'b0;
    dstE = 4'hF; dstM = 4'hF;
    valE = '0; valM = '0;

    tbl[0] = '{4'h3, 1'b0, 4'h2, 4'hF, 64'h1234, 64'h0,
               1, 4'h2, 64'h1234, 4'hF, 64'h0};
    tbl[1] = '{4'hB, 1'b0, 4'h4, 4'h4, 64'h100, 64'hBEEF,
               2, 4'h4, 64'h100, 4'h4, 64'hBEEF};
    tbl[2] = '{4'h2, 1'b0, 4'h1, 4'hF, 64'h77, 64'h0,
               0, 4'hF, 64'h0, 4'hF, 64'h0};
    tbl[3] = '{4'h2, 1'b1, 4'h1, 4'hF, 64'h55, 64'h0,
               1, 4'h1, 64'h55, 4'hF, 64'h0};
    tbl[4] = '{4'h1, 1'b0, 4'hF, 4'hF, 64'h99, 64'h98,
               0, 4'hF, 64'h0, 4'hF, 64'h0};
    tbl[5] = '{4'h5, 1'b0, 4'hF, 4'h7, 64'h1, 64'hCAFE,
               1, 4'h7, 64'hCAFE, 4'hF, 64'h0};
    tbl[6] = '{4'h6, 1'b0, 4'h3, 4'hF, 64'h9, 64'h0,
               1, 4'h3, 64'h9, 4'hF, 64'h0};
    tbl[7] = '{4'hE, 1'b0, 4'h0, 4'h5, 64'h11, 64'h22,
               2, 4'h0, 64'h11, 4'h5, 64'h22};
    tbl[8] = '{4'h2, 1'b0, 4'h1, 4'h6, 64'h44, 64'h33,
               1, 4'h6, 64'h33, 4'hF, 64'h0};
    nop  = tbl[4];
    popq = tbl[1];
    irm  = tbl[0];
    hlt  = '{4'h0, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0,
             0, 4'hF, 64'h0, 4'hF, 64'h0};

    do_reset();
    @(negedge clk);
    foreach (tbl[i]) run(tbl[i], 1'b0);

    // nop then halt; later requests must be ignored
    run(nop, 1'b0);
    run(hlt, 1'b1);
    drive(irm);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("halt_wr_en", wr_en, 0);
      chk("halt_ready", wb_ready, 0);
      chk("halt_count", retire_count, cnt_m);
      chk("halt_sticky", halted, 1);
    end
    wb_valid = 1'b0;

    // reset during WR_E of popq
    do_reset();
    @(negedge clk);
    drive(popq);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("mid_wr_e", wr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_drop", wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_no_m", wr_en, 0);
      chk("mid_count", retire_count, 0);
      chk("mid_halted", halted, 0);
      chk("mid_ready", wb_ready, 1);
    end

    // 17 nops wrap a 4-bit counter to 1
    cnt_m = 4'd0;
    for (int k = 0; k < 17; k++) run(nop, 1'b0);
    chk("wrap_count", retire_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Write-back scheduler between the SEQ write-back stage and a single-write-port register file.
- Accepts one retiring instruction per handshake, with its dstE/valE and dstM/valM pair.
- Serialises the two possible register writes onto the one port, E first, then M.
- Also suppresses not-taken cmov writes, counts retired instructions and latches halt.

Parameters:
- DATA_W, 64, register data width.
- CNT_W, 32, width of the retired-instruction counter.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wb_valid  input  1  write-back request valid.
- wb_ready  output  1  scheduler can accept a request.
- icode  input  4  instruction code of the retiring instruction.
- cnd  input  1  condition result; only used when icode==2.
- dstE  input  4  E destination register ID.
- dstM  input  4  M destination register ID.
- valE  input  DATA_W  ALU result.
- valM  input  DATA_W  memory result.
- wr_en  output  1  register-file write strobe.
- wr_addr  output  4  register-file write address.
- wr_data  output  DATA_W  register-file write data.
- retire  output  1  one-cycle pulse when the instruction's write-back completes.
- retire_count  output  CNT_W  number of retired instructions.
- halted  output  1  sticky; set when a halt instruction (icode 0) retires.

Behaviour:
- Reset (async, rst_n low):
  - State returns to IDLE; pending E/M are discarded.
  - wr_en, retire, halted and retire_count go to 0; wr_addr goes to RNONE; wr_data goes to 0.
  - wb_ready goes to 0 while reset is asserted, and to 1 in the first cycle after release.
  - Reset asserted mid-sequence drops wr_en immediately; the second write never occurs.
- States: IDLE, WR_E, WR_M, RET.
- wb_ready = (state==IDLE) && !halted.
- Accept: the request is accepted on a rising edge with wb_valid && wb_ready. On acceptance:
  - Latch dstE, dstM, valE, valM and icode.
  - E is pending iff dstE!=RNONE and not (icode==2 && cnd==0).
  - M is pending iff dstM!=RNONE.
- Transitions from IDLE after acceptance:
  - E pending -> WR_E.
  - Else M pending -> WR_M.
  - Else -> RET.
- WR_E: wr_en=1, wr_addr=latched dstE, wr_data=latched valE. Next is WR_M if M is pending, otherwise IDLE.
- WR_M: wr_en=1, wr_addr=latched dstM, wr_data=latched valM. Next is IDLE.
- RET: wr_en=0. Next is IDLE.
- retire = 1 in the final cycle of each sequence:
  - WR_E with no M pending;
  - WR_M;
  - RET.
- Latency, measured from the acceptance edge T:
  - First write is in cycle T+1.
  - A two-write instruction retires in T+2.
  - wb_ready returns to 1 in the cycle after retire.
- Ordering: E is always written before M. For popq %rsp (dstE==dstM==4), the final register value is valM.
- Outside WR_E/WR_M: wr_en=0 and wr_addr=RNONE; wr_data holds its last value.
- retire_count increments by 1 on each retire cycle and wraps modulo 2^CNT_W.
- Halt: if the accepted icode==0, halted is set on the retire edge. From then on wb_ready stays 0 until reset; wb_valid is ignored.
- icode values above 11 are scheduled per dstE/dstM like any other. No error flag.
- wb_valid while wb_ready=0 is ignored. The requester must hold its inputs until the handshake completes; the scheduler does not sample them earlier.

Test Plan:
- irmovq: icode=3, dstE=2, dstM=F, valE=0x1234 -> wr_en in T+1 only, wr_addr=2, wr_data=0x1234; retire in T+1; retire_count=1.
- popq %rsp: icode=11, dstE=4, valE=0x100, dstM=4, valM=0xBEEF -> T+1 writes r4=0x100, T+2 writes r4=0xBEEF with retire; wb_ready low during T+1..T+2, high in T+3.
- cmov not taken: icode=2, cnd=0, dstE=1 -> no wr_en; RET in T+1 with retire. Same with cnd=1 -> writes r1.
- nop then halt: icode=1 -> RET, retire, count=1. Then icode=0 -> retire, halted=1, wb_ready stays 0; a further wb_valid produces no writes and no count change.
- Reset mid-popq: assert rst_n=0 during WR_E -> wr_en=0 immediately, no M write after release, count=0, halted=0, wb_ready=1.
- Counter wrap (CNT_W=4): 17 back-to-back nops -> retire_count reads 1 after the 17th retire.
